// File: rtl/frogger_lane_engine.sv
// ---------------------------------------------------------------------------------------------
// frogger_lane_engine
//
// Traffic lane engine for a Frogger-style playfield. A shared prescaler produces a base tick;
// each lane counts base ticks and steps its head one tile left or right when its effective
// period is reached. Car k of a lane sits CAR_SPACING*k tiles after the head, wrapping at
// FIELD_W. The block answers renderer tile queries (o_Car_Hit, one-cycle latency) and detects
// the frog entering a car tile (o_Collided, one pulse per 0->1 overlap transition).
//
// Ports:
//   i_Clk            clock
//   i_Rst            synchronous active-high reset
//   i_Game_Active    run enable; 0 freezes prescaler, counters and heads
//   i_Level          difficulty level (only used when FROGGER_LANE_SPEEDUP_EN is defined)
//   i_Frogger_X/Y    frog tile column/row
//   i_Col_Count_Div  renderer tile column query
//   i_Row_Count_Div  renderer tile row query
//   o_Car_Hit        registered: queried tile holds a car
//   o_Collided       one-cycle collision pulse
//   o_Lane_Step      registered per-lane step pulse, high while the new head value is visible
//
// Optional feature macro: FROGGER_LANE_SPEEDUP_EN
//   defined   -> effective period = max(1, LANE_PERIOD[n] - i_Level)
//   undefined -> effective period = LANE_PERIOD[n], i_Level ignored
// ---------------------------------------------------------------------------------------------
module frogger_lane_engine #(
    parameter int unsigned NUM_LANES     = 5,
    parameter int unsigned CARS_PER_LANE = 2,
    parameter int unsigned FIELD_W       = 14,
    parameter int unsigned FIRST_ROW     = 7,
    parameter int unsigned CAR_SPACING   = 7,
    parameter int unsigned TICK_DIV      = 4000000,
    parameter logic [4*NUM_LANES-1:0] LANE_PERIOD = {NUM_LANES{4'd4}},
    parameter logic [NUM_LANES-1:0]   LANE_DIR    = 5'b10101
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Game_Active,
    input  logic [2:0]           i_Level,
    input  logic [5:0]           i_Frogger_X,
    input  logic [5:0]           i_Frogger_Y,
    input  logic [4:0]           i_Col_Count_Div,
    input  logic [4:0]           i_Row_Count_Div,
    output logic                 o_Car_Hit,
    output logic                 o_Collided,
    output logic [NUM_LANES-1:0] o_Lane_Step
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HW = (FIELD_W > 1) ? $clog2(FIELD_W) : 1;

    // -----------------------------------------------------------------------------------------
    // Prescaler
    // -----------------------------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic          base_tick;

    assign base_tick = i_Game_Active && (presc_q == PW'(TICK_DIV - 1));

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            presc_q <= '0;
        end else if (i_Game_Active) begin
            presc_q <= base_tick ? '0 : presc_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Effective per-lane period
    // -----------------------------------------------------------------------------------------
    logic [NUM_LANES-1:0][3:0] eff_period;

`ifdef FROGGER_LANE_SPEEDUP_EN
    always_comb begin
        eff_period = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            // Clamp at 1 so a high level never stalls or underflows a lane.
            if (LANE_PERIOD[4*n +: 4] > {1'b0, i_Level}) begin
                eff_period[n] = LANE_PERIOD[4*n +: 4] - {1'b0, i_Level};
            end else begin
                eff_period[n] = 4'd1;
            end
        end
    end
`else
    logic unused_level;
    assign unused_level = ^i_Level;

    always_comb begin
        eff_period = LANE_PERIOD;
    end
`endif

    // -----------------------------------------------------------------------------------------
    // Step counters and lane heads
    // -----------------------------------------------------------------------------------------
    logic [NUM_LANES-1:0][3:0]    step_cnt_q, step_cnt_d;
    logic [NUM_LANES-1:0][HW-1:0] head_q, head_d;
    logic [NUM_LANES-1:0]         lane_step_q, lane_step_d;

    always_comb begin
        step_cnt_d  = step_cnt_q;
        head_d      = head_q;
        lane_step_d = '0;
        if (base_tick) begin
            for (int n = 0; n < NUM_LANES; n++) begin
                // >= rather than == keeps a lane moving if its period shrinks below the count.
                if (({1'b0, step_cnt_q[n]} + 5'd1) >= {1'b0, eff_period[n]}) begin
                    step_cnt_d[n]  = '0;
                    lane_step_d[n] = 1'b1;
                    if (LANE_DIR[n]) begin
                        head_d[n] = (head_q[n] == HW'(FIELD_W - 1)) ? '0 : head_q[n] + 1'b1;
                    end else begin
                        head_d[n] = (head_q[n] == '0) ? HW'(FIELD_W - 1) : head_q[n] - 1'b1;
                    end
                end else begin
                    step_cnt_d[n] = step_cnt_q[n] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            step_cnt_q  <= '0;
            lane_step_q <= '0;
            for (int n = 0; n < NUM_LANES; n++) begin
                head_q[n] <= LANE_DIR[n] ? '0 : HW'(FIELD_W - 1);
            end
        end else begin
            step_cnt_q  <= step_cnt_d;
            head_q      <= head_d;
            lane_step_q <= lane_step_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Car positions
    // -----------------------------------------------------------------------------------------
    logic [NUM_LANES-1:0][CARS_PER_LANE-1:0][HW-1:0] car_x;
    logic [HW:0]                                     car_sum;

    // The per-car offset is pre-reduced mod FIELD_W, so head + offset < 2*FIELD_W and a single
    // conditional subtract completes the modulo; the extra bit keeps the sum from overflowing.
    always_comb begin
        car_x   = '0;
        car_sum = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            for (int k = 0; k < CARS_PER_LANE; k++) begin
                car_sum = {1'b0, head_q[n]} + (HW+1)'((k * CAR_SPACING) % FIELD_W);
                if (car_sum >= (HW+1)'(FIELD_W)) begin
                    car_sum = car_sum - (HW+1)'(FIELD_W);
                end
                car_x[n][k] = car_sum[HW-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Frog overlap and renderer query
    // -----------------------------------------------------------------------------------------
    // Rows outside the lane band match no lane index, so they can never hit.
    logic overlap;
    logic car_hit_d;

    always_comb begin
        overlap   = 1'b0;
        car_hit_d = 1'b0;
        for (int n = 0; n < NUM_LANES; n++) begin
            for (int k = 0; k < CARS_PER_LANE; k++) begin
                if ((32'(i_Frogger_Y) == 32'(FIRST_ROW + n)) &&
                    (32'(i_Frogger_X) == 32'(car_x[n][k]))) begin
                    overlap = 1'b1;
                end
                if ((32'(i_Row_Count_Div) == 32'(FIRST_ROW + n)) &&
                    (32'(i_Col_Count_Div) == 32'(car_x[n][k]))) begin
                    car_hit_d = 1'b1;
                end
            end
        end
    end

    logic overlap_q;
    logic collided_q;
    logic car_hit_q;

    // Query and collision paths stay live while the game is paused.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            overlap_q  <= 1'b0;
            collided_q <= 1'b0;
            car_hit_q  <= 1'b0;
        end else begin
            overlap_q  <= overlap;
            collided_q <= overlap && !overlap_q;
            car_hit_q  <= car_hit_d;
        end
    end

    assign o_Car_Hit   = car_hit_q;
    assign o_Collided  = collided_q;
    assign o_Lane_Step = lane_step_q;

endmodule

// File: tb/tb_frogger_lane_engine.sv
// ---------------------------------------------------------------------------------------------
// tb_frogger_lane_engine
//
// Scoreboard bench. A reference model derives lane heads in closed form from the number of
// active cycles since reset (ticks = cycles / TICK_DIV, steps = ticks / period) and pushes the
// expected registered outputs each clock; a monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------------------------
module tb_frogger_lane_engine;

    localparam int NL = 5;
    localparam int CPL = 2;
    localparam int FW = 14;
    localparam int FR = 7;
    localparam int SP = 7;
    localparam int TD = 2;
    localparam logic [19:0] LP = {5{4'd4}};
    localparam logic [4:0]  LD = 5'b10101;

    logic          clk;
    logic          rst;
    logic          active;
    logic [2:0]    level;
    logic [5:0]    fx;
    logic [5:0]    fy;
    logic [4:0]    qc;
    logic [4:0]    qr;
    logic          car_hit;
    logic          collided;
    logic [NL-1:0] lane_step;

    frogger_lane_engine #(
        .NUM_LANES    (NL),
        .CARS_PER_LANE(CPL),
        .FIELD_W      (FW),
        .FIRST_ROW    (FR),
        .CAR_SPACING  (SP),
        .TICK_DIV     (TD),
        .LANE_PERIOD  (LP),
        .LANE_DIR     (LD)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Game_Active  (active),
        .i_Level        (level),
        .i_Frogger_X    (fx),
        .i_Frogger_Y    (fy),
        .i_Col_Count_Div(qc),
        .i_Row_Count_Div(qr),
        .o_Car_Hit      (car_hit),
        .o_Collided     (collided),
        .o_Lane_Step    (lane_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          hit;
        logic          col;
        logic [NL-1:0] step;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;
    bit   started = 0;
    int   act_cnt = 0;
    bit   prev_ov = 0;
    int   lvl_lat = 0;

    // ---------------- reference model ----------------
    function automatic int period(int n);
        int p;
        p = int'(LP[4*n +: 4]);
`ifdef FROGGER_LANE_SPEEDUP_EN
        p = p - lvl_lat;
        if (p < 1) p = 1;
`endif
        return p;
    endfunction

    function automatic int steps(int n, int a);
        return (a / TD) / period(n);
    endfunction

    function automatic int head(int n, int a);
        int s;
        s = steps(n, a) % FW;
        return LD[n] ? s : (FW - 1 - s);
    endfunction

    function automatic bit hit_at(int a, int row, int col);
        int n;
        if (row < FR || row >= FR + NL) return 1'b0;
        n = row - FR;
        for (int k = 0; k < CPL; k++) begin
            if ((head(n, a) + k * SP) % FW == col) return 1'b1;
        end
        return 1'b0;
    endfunction

    initial begin
        exp_t e;
        bit   ov;
        forever begin
            @(posedge clk);
            if (rst) begin
                e.hit = 1'b0; e.col = 1'b0; e.step = '0;
                q.push_back(e);
                act_cnt = 0;
                prev_ov = 1'b0;
                lvl_lat = int'(level);
                started = 1'b1;
            end else if (started) begin
                e.hit   = hit_at(act_cnt, int'(qr), int'(qc));
                ov      = hit_at(act_cnt, int'(fy), int'(fx));
                e.col   = ov && !prev_ov;
                prev_ov = ov;
                e.step  = '0;
                if (active) begin
                    for (int n = 0; n < NL; n++) begin
                        if (steps(n, act_cnt + 1) != steps(n, act_cnt)) e.step[n] = 1'b1;
                    end
                    act_cnt++;
                end
                q.push_back(e);
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) begin
                $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.col) pulses++;
                chk("car_hit", 32'(car_hit), 32'(e.hit));
                chk("collided", 32'(collided), 32'(e.col));
                chk("lane_step", 32'(lane_step), 32'(e.step));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(logic [2:0] lv);
        rst   = 1'b1;
        level = lv;
        cyc(1);
        rst = 1'b0;
    endtask

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        summary();
    end

    initial begin
        rst = 1'b1; active = 1'b0; level = 3'd0;
        fx = 6'd0; fy = 6'd0; qc = 5'd0; qr = 5'd0;
        cyc(2);

        // First step of lanes 0/1 after 8 active clocks, frog on lane 0 at X=7 then X=8.
        do_reset(3'd0);
        active = 1'b1; fx = 6'd7; fy = 6'd7;
        for (int i = 0; i < 140; i++) begin
            qc = 5'(i % 16);
            qr = 5'((i % 3 == 0) ? 7 : 8);
            if (i == 70) fx = 6'd8;
            cyc(1);
        end

        // Frog outside the lane band, queries at (0,7) and (0,6).
        fx = 6'd3; fy = 6'd12;
        for (int i = 0; i < 60; i++) begin
            qc = 5'd0;
            qr = 5'((i % 2 == 0) ? 7 : 6);
            cyc(1);
        end

        // Pause: heads freeze, queries and collisions stay live.
        active = 1'b0; fy = 6'd7;
        for (int i = 0; i < 100; i++) begin
            qc = 5'(i % 14);
            qr = 5'(7 + i % 5);
            fx = 6'(i % 14);
            cyc(1);
        end

        // Reset mid-step and on a step cycle.
        active = 1'b1;
        cyc(5);
        do_reset(3'd0);
        cyc(7);
        do_reset(3'd0);
        cyc(8);
        do_reset(3'd0);

        // Level handling (period reduction only with the speedup macro).
        do_reset(3'd3);
        for (int i = 0; i < 40; i++) begin qc = 5'(i % 14); qr = 5'd7; cyc(1); end
        do_reset(3'd7);
        for (int i = 0; i < 40; i++) begin qc = 5'(i % 14); qr = 5'd7; cyc(1); end

        // Randomized traffic.
        do_reset(3'd0);
        for (int i = 0; i < 3000; i++) begin
            active = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0) begin
                fx = 6'($urandom_range(0, 15));
                fy = 6'($urandom_range(4, 14));
            end
            qc = 5'($urandom_range(0, 15));
            qr = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                             : 5'($urandom_range(6, 12));
`ifndef FROGGER_LANE_SPEEDUP_EN
            level = 3'($urandom_range(0, 7));
`endif
            if ($urandom_range(0, 399) == 0) begin
                do_reset(3'($urandom_range(0, 7)));
            end else begin
                cyc(1);
            end
        end

        cyc(3);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
        end
        checks++;
        if (pulses == 0) begin
            errors++;
            $display("FAIL collision_coverage: got %0d expected pulses nonzero", pulses);
        end
        summary();
    end

endmodule
